offchip_mem_ctrl: RTL

//   Off-chip memory model/controller directly downstream of the unified cache's memory interface.

---
 rtl/offchip_mem_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/offchip_mem_ctrl.sv
// offchip_mem_ctrl: off-chip memory model serving 4-word read bursts and single-word writes over a shared bus.
// Define OFFMEM_CRIT_WORD_FIRST_EN to start each read burst at the requested word instead of word 0.
module offchip_mem_ctrl #(
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        rrqst_i,
    input  logic        rdacpt_i,
    input  logic        wrqst_i,
    output logic        rrdy_o,
    output logic        rdrdy_o,
    output logic        wacpt_o,
    inout  wire  [15:0] offdata_io,
    output logic        busy_o
);
    typedef enum logic [2:0] {
        IDLE, RD_ACK, RD_WAIT, RD_BURST, WR_DATA, WR_WAIT, WR_DONE
    } state_t;

    localparam logic [7:0] RD_END = 8'(RD_LAT - 1);
    localparam logic [7:0] WR_END = 8'(WR_LAT - 1);

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        beat_q, beat_d;
    logic              mem_we;
    logic              rrdy_q, rdrdy_q, wacpt_q, busy_q;
    logic [15:0]       rdata_q;
    logic [15:0]       mem_q [2**MEM_AW];

    assign offdata_io = rdrdy_q ? rdata_q : 16'hzzzz;
    assign rrdy_o     = rrdy_q;
    assign rdrdy_o    = rdrdy_q;
    assign wacpt_o    = wacpt_q;
    assign busy_o     = busy_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wrqst_i || rrqst_i) addr_d = offdata_io[MEM_AW-1:0];
                state_d = wrqst_i ? WR_DATA : rrqst_i ? RD_ACK : IDLE;
            end
            RD_ACK: begin
`ifdef OFFMEM_CRIT_WORD_FIRST_EN
                idx_d = addr_q[1:0];
`else
                idx_d = 2'd0;
`endif
                beat_d  = 2'd0;
                cnt_d   = 8'd0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = (cnt_q == RD_END) ? RD_BURST : RD_WAIT;
            end
            RD_BURST: begin
                // idx wraps inside the block; beat counts accepted words
                if (rdacpt_i) begin
                    idx_d   = idx_q + 2'd1;
                    beat_d  = beat_q + 2'd1;
                    state_d = (beat_q == 2'd3) ? IDLE : RD_BURST;
                end
            end
            WR_DATA: begin
                data_d  = offdata_io;
                cnt_d   = 8'd0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                cnt_d   = cnt_q + 8'd1;
                mem_we  = (cnt_q == WR_END);
                state_d = mem_we ? WR_DONE : WR_WAIT;
            end
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            rrdy_q  <= 1'b0;
            rdrdy_q <= 1'b0;
            wacpt_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            rrdy_q  <= (state_d == RD_ACK);
            rdrdy_q <= (state_d == RD_BURST);
            wacpt_q <= (state_d == WR_DONE);
            busy_q  <= (state_d != IDLE);
            rdata_q <= mem_q[{addr_d[MEM_AW-1:2], idx_d}];
        end
    end

    // Array is never cleared; an aborted write never reaches this edge
    always_ff @(posedge clock_i) begin
        if (mem_we && !reset_i) mem_q[addr_q] <= data_q;
    end
endmodule
